matrix_keypad_scanner: RTL and testbench

//  Scans a 4x4 active-low matrix keypad and emits debounced hex key codes (0-F) as events.

---
 rtl/matrix_keypad_scanner_pkg.sv | 44 ++++
 rtl/matrix_keypad_scanner_tick.sv | 25 ++
 rtl/matrix_keypad_scanner.sv | 170 +++++++++++++++++
 tb/tb_matrix_keypad_scanner.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_keypad_scanner_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM encoding, idle patterns,
// defaults and column/row helper functions.
package keypad_pkg;

    localparam int unsigned CODE_W           = 4;
    localparam logic [15:0] CLK_DIV_DEFAULT  = 16'd49999;
    localparam logic [7:0]  DEBOUNCE_DEFAULT = 8'd20;

    localparam logic [3:0] ROW_IDLE = 4'b1111;
    localparam logic [3:0] COL_NONE = 4'hF;

    typedef logic [1:0] state_t;

    localparam state_t SCAN     = 2'd0;
    localparam state_t DEBOUNCE = 2'd1;
    localparam state_t PRESSED  = 2'd2;
    localparam state_t RELEASE  = 2'd3;

    typedef struct packed {
        logic       hit;
        logic [1:0] idx;
    } col_hit_t;

    // hit only when exactly one column is low; 2+ low is treated as ghosting
    function automatic col_hit_t decode_col(input logic [3:0] col);
        col_hit_t    r;
        int unsigned n;
        r = '0;
        n = 0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!col[i]) begin
                n++;
                r.idx = i[1:0];
            end
        end
        r.hit = (n == 1);
        return r;
    endfunction

    function automatic logic [3:0] one_cold(input logic [1:0] idx);
        return ROW_IDLE ^ (4'b0001 << idx);
    endfunction

endpackage

// File: rtl/matrix_keypad_scanner_tick.sv
// Free-running scan tick: counts 0..CLK_DIV and flags the terminal count.
import keypad_pkg::*;

module scan_tick_gen #(
    parameter logic [15:0] CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    logic [15:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CLK_DIV);

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/matrix_keypad_scanner.sv
// 4x4 active-low keypad scanner with debounce and valid/ack key events.
// Optional macro KEYPAD_DIGITS_EN adds a six-digit shift history on `digits`.
import keypad_pkg::*;

module matrix_keypad_scanner #(
    parameter logic [15:0] CLK_DIV        = CLK_DIV_DEFAULT,
    parameter logic [7:0]  DEBOUNCE_TICKS = DEBOUNCE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        col_in,
    output logic [3:0]        row_out,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    input  logic              key_ack,
    output logic              key_held,
    output logic              overrun
`ifdef KEYPAD_DIGITS_EN
    ,
    output logic [23:0]       digits
`endif
);

    logic              tick;
    logic [3:0]        col_m_q, col_s_q;
    state_t            state_q, state_d;
    logic [1:0]        row_idx_q, row_idx_d;
    logic [1:0]        cand_row_q, cand_row_d;
    logic [1:0]        cand_col_q, cand_col_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [CODE_W-1:0] key_code_q, key_code_d;
    logic              key_valid_q, key_valid_d;
    logic              overrun_q, overrun_d;
    logic              evt;
    col_hit_t          hit;
    logic [3:0]        cand_pat;

    scan_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_m_q <= COL_NONE;
            col_s_q <= COL_NONE;
        end else begin
            col_m_q <= col_in;
            col_s_q <= col_m_q;
        end
    end

    assign hit      = decode_col(col_s_q);
    assign cand_pat = one_cold(cand_col_q);

    // One counter serves both press and release debounce; the states never overlap.
    always_comb begin
        state_d    = state_q;
        row_idx_d  = row_idx_q;
        cand_row_d = cand_row_q;
        cand_col_d = cand_col_q;
        cnt_d      = cnt_q;
        evt        = 1'b0;
        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (hit.hit) begin
                        cand_row_d = row_idx_q;
                        cand_col_d = hit.idx;
                        cnt_d      = 8'd1;
                        state_d    = DEBOUNCE;
                    end else begin
                        row_idx_d = row_idx_q + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (col_s_q == cand_pat) begin
                        if (cnt_q >= DEBOUNCE_TICKS) begin
                            state_d = PRESSED;
                            evt     = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end else begin
                        state_d   = SCAN;
                        row_idx_d = row_idx_q + 2'd1;
                    end
                end
                PRESSED: begin
                    if (col_s_q == COL_NONE) begin
                        cnt_d   = 8'd1;
                        state_d = RELEASE;
                    end
                end
                default: begin
                    if (col_s_q == COL_NONE) begin
                        if (cnt_q >= DEBOUNCE_TICKS) begin
                            state_d   = SCAN;
                            row_idx_d = row_idx_q + 2'd1;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end else begin
                        state_d = PRESSED;
                    end
                end
            endcase
        end
    end

    // A new event wins over a same-cycle ack, and an ack excuses the overwrite.
    always_comb begin
        key_code_d  = key_code_q;
        key_valid_d = key_valid_q;
        overrun_d   = 1'b0;
        if (evt) begin
            key_code_d  = {cand_row_q, cand_col_q};
            key_valid_d = 1'b1;
            overrun_d   = key_valid_q && !key_ack;
        end else if (key_ack && key_valid_q) begin
            key_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SCAN;
            row_idx_q   <= '0;
            cand_row_q  <= '0;
            cand_col_q  <= '0;
            cnt_q       <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_idx_q   <= row_idx_d;
            cand_row_q  <= cand_row_d;
            cand_col_q  <= cand_col_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign row_out   = one_cold(row_idx_q);
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign overrun   = overrun_q;
    assign key_held  = (state_q == PRESSED) || (state_q == RELEASE);

`ifdef KEYPAD_DIGITS_EN
    logic [23:0] digits_q, digits_d;

    always_comb begin
        digits_d = digits_q;
        if (evt) digits_d = {digits_q[19:0], cand_row_q, cand_col_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) digits_q <= '0;
        else        digits_q <= digits_d;
    end

    assign digits = digits_q;
`endif

endmodule

// File: tb/tb_matrix_keypad_scanner.sv
// Scoreboard bench for matrix_keypad_scanner with a keypad model driving col_in.
module tb_matrix_keypad_scanner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  col_in;
    logic [3:0]  row_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ack;
    logic        key_held;
    logic        overrun;
`ifdef KEYPAD_DIGITS_EN
    logic [23:0] digits;
`endif

    logic [15:0] kmask = '0;
    logic        mon_ack = 1'b0;
    logic        tst_ack = 1'b0;
    logic        auto_ack = 1'b1;
    int          cyc;
    int          checks = 0;
    int          errors = 0;
    int          ovr_cnt = 0;
    int          exp_q[$];

    assign key_ack = mon_ack | tst_ack;

    always #5 clk = ~clk;

    matrix_keypad_scanner #(.CLK_DIV(16'd9), .DEBOUNCE_TICKS(8'd3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .col_in   (col_in),
        .row_out  (row_out),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_ack  (key_ack),
        .key_held (key_held),
        .overrun  (overrun)
`ifdef KEYPAD_DIGITS_EN
        ,
        .digits   (digits)
`endif
    );

    // keypad: a closed key pulls its column low while its row is driven
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (kmask[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) if (overrun) ovr_cnt++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitor: pops one expected code per presented event and acknowledges it
    initial begin
        int e;
        forever begin
            @(negedge clk);
            if (rst_n && auto_ack && key_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_event", {31'd0, key_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_code", {28'd0, key_code}, e);
                end
                mon_ack = 1'b1;
                @(negedge clk);
                mon_ack = 1'b0;
            end
        end
    end

    task automatic wait_ticks(input int n);
        repeat (n * 10) @(posedge clk);
    endtask

    task automatic press(input int r, input int c, input int hold, input int gap, input bit expect_evt);
        if (expect_evt) exp_q.push_back(r * 4 + c);
        kmask = 16'd1 << (r * 4 + c);
        wait_ticks(hold);
        kmask = '0;
        wait_ticks(gap);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 1000 && (exp_q.size() != 0 || key_valid); i++) @(negedge clk);
        chk("drain_pending", exp_q.size(), 32'd0);
    endtask

    // finds the tick on which the scan stops rotating (first sampling tick)
    task automatic wait_freeze(output int t0);
        logic [3:0] prev;
        bit         have;
        t0 = -1;
        have = 0;
        prev = '0;
        for (int i = 0; i < 300 && t0 < 0; i++) begin
            @(negedge clk);
            if (cyc % 10 == 9) begin
                prev = row_out;
                have = 1;
            end else if (cyc % 10 == 0 && have && row_out == prev) begin
                t0 = cyc;
            end
        end
        chk("freeze_found", {31'd0, t0 >= 0}, 32'd1);
    endtask

    initial begin
        int t0;
        int ovr0;
        logic [3:0] prev;

        // reset state and idle row walk
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_row_out", {28'd0, row_out}, 32'hE);
        chk("rst_key_code", {28'd0, key_code}, 32'h0);
        chk("rst_key_valid", {31'd0, key_valid}, 32'd0);
        chk("rst_key_held", {31'd0, key_held}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("idle_row_walk", {28'd0, row_out}, {28'd0, ~(4'b0001 << (i % 4))});
            chk("idle_valid", {31'd0, key_valid}, 32'd0);
            repeat (10) @(posedge clk);
            @(negedge clk);
        end

        // row2/col1 press then release
        exp_q.push_back(9);
        kmask = 16'd1 << 9;
        wait_ticks(10);
        @(negedge clk);
        chk("held_while_down", {31'd0, key_held}, 32'd1);
        kmask = '0;
        wait_ticks(6);
        @(negedge clk);
        chk("held_after_release", {31'd0, key_held}, 32'd0);
        wait_drain();

        // bounce on row1/col3 before a solid press
        exp_q.push_back(7);
        kmask = 16'd1 << 7;
        repeat (10) @(posedge clk);
        kmask = '0;
        repeat (10) @(posedge clk);
        press(1, 3, 12, 8, 1'b0);
        wait_drain();

        // two keys in one row: ghost, scan keeps rotating
        kmask = 16'd1 | (16'd1 << 2);
        while (cyc % 10 != 5) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            prev = row_out;
            repeat (10) @(negedge clk);
            chk("ghost_rotate", {28'd0, row_out}, {28'd0, prev[2:0], prev[3]});
            chk("ghost_not_held", {31'd0, key_held}, 32'd0);
        end
        kmask = '0;
        wait_ticks(4);
        wait_drain();

        // unacked event overwritten -> overrun
        auto_ack = 1'b0;
        press(0, 3, 12, 8, 1'b0);
        chk("first_valid", {31'd0, key_valid}, 32'd1);
        chk("first_code", {28'd0, key_code}, 32'h3);
        ovr0 = ovr_cnt;
        press(3, 0, 12, 8, 1'b0);
        chk("ovr_code", {28'd0, key_code}, 32'hC);
        chk("ovr_valid", {31'd0, key_valid}, 32'd1);
        chk("ovr_pulses", ovr_cnt - ovr0, 32'd1);

        // ack landing on the event edge: no overrun, valid stays set
        ovr0 = ovr_cnt;
        kmask = 16'd1 << 5;
        wait_freeze(t0);
        while (cyc < t0 + 29 && t0 >= 0) @(negedge clk);
        tst_ack = 1'b1;
        @(negedge clk);
        tst_ack = 1'b0;
        chk("ackevt_valid", {31'd0, key_valid}, 32'd1);
        chk("ackevt_code", {28'd0, key_code}, 32'h5);
        wait_ticks(3);
        kmask = '0;
        wait_ticks(8);
        chk("ackevt_no_ovr", ovr_cnt - ovr0, 32'd0);
        @(negedge clk);
        tst_ack = 1'b1;
        @(negedge clk);
        tst_ack = 1'b0;
        @(negedge clk);
        chk("manual_ack_clears", {31'd0, key_valid}, 32'd0);
        auto_ack = 1'b1;

        // randomized presses against the code = row*4+col rule
        for (int i = 0; i < 8; i++)
            press($urandom_range(0, 3), $urandom_range(0, 3), 12 + $urandom_range(0, 4), 8, 1'b1);
        wait_drain();

        // reset during debounce aborts the press
        kmask = 16'd1 << 4;
        wait_freeze(t0);
        wait_ticks(1);
        @(negedge clk);
        rst_n = 1'b0;
        kmask = '0;
        @(negedge clk);
        chk("midrst_row_out", {28'd0, row_out}, 32'hE);
        chk("midrst_code", {28'd0, key_code}, 32'h0);
        chk("midrst_valid", {31'd0, key_valid}, 32'd0);
        chk("midrst_held", {31'd0, key_held}, 32'd0);
        chk("midrst_overrun", {31'd0, overrun}, 32'd0);
        rst_n = 1'b1;
        wait_ticks(15);
        @(negedge clk);
        chk("midrst_no_event", {31'd0, key_valid}, 32'd0);

`ifdef KEYPAD_DIGITS_EN
        press(0, 1, 12, 8, 1'b1);
        press(0, 2, 12, 8, 1'b1);
        press(0, 3, 12, 8, 1'b1);
        wait_drain();
        chk("digits_history", digits, 32'h000123);
`endif

        wait_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
